dmem_responder: RTL and testbench

Memory-mapped responder on the processor's data-memory port. It answers every `address_dmem`/`data`/`wren` access from the processor. Addresses below 0xFF0 pass through to the synchronous dmem RAM. The top 16 words form a peripheral window containing an output FIFO, a status register and a cycle counter. It sits between the processor and the dmem instance and returns read data with the same one-cycle latency as the RAM, so the processor cannot tell a peripheral access from a RAM access.

---
 rtl/dmem_resp_pkg.sv | 26 ++
 rtl/dmem_resp_fifo.sv | 55 +++++
 rtl/dmem_responder.sv | 103 ++++++++++
 tb/tb_dmem_responder.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_resp_pkg.sv
// Shared constants for the data-memory responder: peripheral offsets, STATUS layout and default window base.
package dmem_resp_pkg;

  localparam logic [3:0]  OFF_OUT_DATA = 4'd0;
  localparam logic [3:0]  OFF_STATUS   = 4'd1;
  localparam logic [3:0]  OFF_CYCLE    = 4'd2;

  localparam int ST_EMPTY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_CNT_LSB = 4;

  localparam logic [11:0] DEF_PERIPH_BASE = 12'hFF0;

  function automatic logic [31:0] pack_status(input logic empty, input logic full,
                                              input logic ovf, input logic [4:0] cnt);
    logic [31:0] v;
    v = '0;
    v[ST_EMPTY] = empty;
    v[ST_FULL]  = full;
    v[ST_OVF]   = ovf;
    v[ST_CNT_LSB +: 5] = cnt;
    return v;
  endfunction

endpackage

// File: rtl/dmem_resp_fifo.sv
// Synchronous power-of-two FIFO; the head output holds the last popped word while empty.
module dmem_resp_fifo #(
  parameter  int DEPTH = 4,
  parameter  int W     = 32,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          i_clock,
  input  logic          i_rst_n,
  input  logic          i_push,
  input  logic [W-1:0]  i_data,
  input  logic          i_pop_req,
  output logic          o_full,
  output logic          o_empty,
  output logic [CW-1:0] o_count,
  output logic [W-1:0]  o_head
);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [W-1:0]  r_last;
  logic          w_pop;
  logic          w_push;

  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));
  assign w_pop   = i_pop_req & ~o_empty;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign w_push  = i_push & (~o_full | w_pop);
  assign o_head  = o_empty ? r_last : r_mem[r_rd_ptr];

  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_last   <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_last   <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: RAM pass-through plus a 16-word peripheral window (output FIFO, STATUS, CYCLE).
// Optional macro DMEM_RESP_CYCLE_COUNTER_EN adds the free-running CYCLE counter at offset 2.
module dmem_responder
  import dmem_resp_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [11:0] PERIPH_BASE = DEF_PERIPH_BASE
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] address_dmem,
  input  logic [31:0] data,
  input  logic        wren,
  output logic [31:0] q_dmem,
  output logic [11:0] ram_address,
  output logic [31:0] ram_data,
  output logic        ram_wren,
  input  logic [31:0] ram_q,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic          w_in_periph;
  logic [3:0]    w_off;
  logic          w_push_req;
  logic          w_ovf_set;
  logic          w_ovf_clr;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [31:0]   w_cycle;
  logic [31:0]   w_rd_val;
  logic          r_ovf;
  logic          r_rd_sel;
  logic [31:0]   r_rd_val;

  assign w_in_periph = (address_dmem[11:4] == PERIPH_BASE[11:4]);
  assign w_off       = address_dmem[3:0];
  assign ram_address = address_dmem;
  assign ram_data    = data;
  assign ram_wren    = wren & (address_dmem < PERIPH_BASE);

  assign w_push_req = wren & w_in_periph & (w_off == OFF_OUT_DATA);
  // Full implies non-empty, so the only way a full FIFO takes a push is a same-edge pop.
  assign w_ovf_set  = w_push_req & w_full & ~out_ready;
  assign w_ovf_clr  = wren & w_in_periph & (w_off == OFF_STATUS) & data[ST_OVF];

  // out_valid/out_ready: a word transfers on every rising edge where both are high;
  // out_valid never depends on out_ready, and a word pushed this edge is not popped this edge.
  dmem_resp_fifo #(.DEPTH(FIFO_DEPTH), .W(32)) u_fifo (
    .i_clock   (clock),
    .i_rst_n   (reset),
    .i_push    (w_push_req),
    .i_data    (data),
    .i_pop_req (out_ready),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (w_count),
    .o_head    (out_data)
  );
  assign out_valid = ~w_empty;

`ifdef DMEM_RESP_CYCLE_COUNTER_EN
  logic [31:0] r_cycle;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                                             r_cycle <= '0;
    else if (wren && w_in_periph && (w_off == OFF_CYCLE))   r_cycle <= data;
    else                                                    r_cycle <= r_cycle + 32'd1;
  end
  assign w_cycle = r_cycle;
`else
  assign w_cycle = '0;
`endif

  always_comb begin
    w_rd_val = '0;
    case (w_off)
      OFF_STATUS: w_rd_val = pack_status(w_empty, w_full, r_ovf, 5'(w_count));
      OFF_CYCLE:  w_rd_val = w_cycle;
      default:    w_rd_val = '0;
    endcase
  end

  // Reset selects the peripheral path with a zero value so q_dmem reads 0 until the first access.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ovf    <= 1'b0;
      r_rd_sel <= 1'b1;
      r_rd_val <= '0;
    end else begin
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;
      r_rd_sel <= w_in_periph;
      r_rd_val <= w_rd_val;
    end
  end

  assign q_dmem = r_rd_sel ? r_rd_val : ram_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, hand-written corner sequences and random traffic vs a queue model.
module tb_dmem_responder;

  localparam int DEPTH = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [11:0] address_dmem = '0;
  logic [31:0] data = '0;
  logic        wren = 1'b0;
  logic [31:0] q_dmem;
  logic [11:0] ram_address;
  logic [31:0] ram_data;
  logic        ram_wren;
  logic [31:0] ram_q = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;

  dmem_responder #(.FIFO_DEPTH(DEPTH), .PERIPH_BASE(12'hFF0)) dut (
    .clock        (clock),
    .reset        (reset),
    .address_dmem (address_dmem),
    .data         (data),
    .wren         (wren),
    .q_dmem       (q_dmem),
    .ram_address  (ram_address),
    .ram_data     (ram_data),
    .ram_wren     (ram_wren),
    .ram_q        (ram_q),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data)
  );

  // clock / reset block and the synchronous RAM the responder fronts
  always #5 clock = ~clock;

  logic [31:0] bench_mem [4096];
  always @(posedge clock) begin
    if (ram_wren) bench_mem[ram_address] <= ram_data;
    ram_q <= bench_mem[ram_address];
  end

  // reference model state
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m_fifo[$];
  logic [31:0] m_last;
  bit          m_ovf;
  logic [31:0] m_cycle;
  logic [31:0] ref_ram [4096];

  typedef struct {
    logic [11:0] addr;
    logic [31:0] wdata;
    bit          wr;
    bit          rdy;
    bit          exp_valid;
    logic [31:0] exp_head;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] m_read(input logic [11:0] a);
    int n;
    n = m_fifo.size();
    if (a < 12'hFF0) return ref_ram[a];
    if (a[3:0] == 4'd1)
      return (32'(n) << 4) | (m_ovf ? 32'd4 : 32'd0) | ((n == DEPTH) ? 32'd2 : 32'd0) | ((n == 0) ? 32'd1 : 32'd0);
`ifdef DMEM_RESP_CYCLE_COUNTER_EN
    if (a[3:0] == 4'd2) return m_cycle;
`endif
    return 32'd0;
  endfunction

  task automatic model_reset();
    m_fifo.delete();
    exp_q.delete();
    m_ovf   = 1'b0;
    m_cycle = '0;
    m_last  = '0;
  endtask

  // driver: one processor access; checks pre-edge outputs, then the read data one cycle later
  task automatic step(input logic [11:0] a, input logic [31:0] d, input bit w, input bit rdy,
                      output bit o_valid, output logic [31:0] o_head, output bit o_wren,
                      output logic [31:0] o_q);
    bit periph, pop, push, full_pre, ovf_set;
    address_dmem = a;
    data         = d;
    wren         = w;
    out_ready    = rdy;
    #1;
    o_valid = out_valid;
    o_head  = out_data;
    o_wren  = ram_wren;
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_fifo.size() != 0});
    chk("out_data", out_data, (m_fifo.size() != 0) ? m_fifo[0] : m_last);
    chk("ram_wren", {31'd0, ram_wren}, {31'd0, w && (a < 12'hFF0)});
    exp_q.push_back(m_read(a));

    periph   = (a >= 12'hFF0);
    full_pre = (m_fifo.size() == DEPTH);
    pop      = (m_fifo.size() != 0) && rdy;
    push     = w && periph && (a[3:0] == 4'd0);
    ovf_set  = 1'b0;
    if (pop) m_last = m_fifo.pop_front();
    if (push) begin
      if (!full_pre || pop) m_fifo.push_back(d);
      else                  ovf_set = 1'b1;
    end
    if (ovf_set) m_ovf = 1'b1;
    else if (w && periph && (a[3:0] == 4'd1) && d[2]) m_ovf = 1'b0;
    if (w && periph && (a[3:0] == 4'd2)) m_cycle = d;
    else                                 m_cycle = m_cycle + 32'd1;
    if (w && !periph) ref_ram[a] = d;

    @(posedge clock);
    #1;
    o_q = q_dmem;
    chk("q_dmem", q_dmem, exp_q.pop_front());
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #1;
    model_reset();
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_q_dmem", q_dmem, 32'd0);
    chk("rst_out_data", out_data, 32'd0);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    bit          v;
    bit          wr_o;
    logic [31:0] h;
    logic [31:0] q;
    logic [11:0] a;

    for (int i = 0; i < 4096; i++) begin
      bench_mem[i] = '0;
      ref_ram[i]   = '0;
    end

    tbl[0]  = '{12'hFF0, 32'hA, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0};
    tbl[1]  = '{12'hFF0, 32'hB, 1'b1, 1'b0, 1'b1, 32'hA, 32'h0};
    tbl[2]  = '{12'hFF0, 32'hC, 1'b1, 1'b0, 1'b1, 32'hA, 32'h0};
    tbl[3]  = '{12'hFF0, 32'hD, 1'b1, 1'b0, 1'b1, 32'hA, 32'h0};
    tbl[4]  = '{12'hFF0, 32'hE, 1'b1, 1'b0, 1'b1, 32'hA, 32'h0};
    tbl[5]  = '{12'hFF1, 32'h0, 1'b0, 1'b0, 1'b1, 32'hA, 32'h046};
    tbl[6]  = '{12'hFF1, 32'h4, 1'b1, 1'b0, 1'b1, 32'hA, 32'h046};
    tbl[7]  = '{12'hFF1, 32'h0, 1'b0, 1'b0, 1'b1, 32'hA, 32'h042};
    tbl[8]  = '{12'hFF3, 32'h0, 1'b0, 1'b1, 1'b1, 32'hA, 32'h0};
    tbl[9]  = '{12'hFF3, 32'h0, 1'b0, 1'b1, 1'b1, 32'hB, 32'h0};
    tbl[10] = '{12'hFF3, 32'h0, 1'b0, 1'b1, 1'b1, 32'hC, 32'h0};
    tbl[11] = '{12'hFF3, 32'h0, 1'b0, 1'b1, 1'b1, 32'hD, 32'h0};
    tbl[12] = '{12'hFF1, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h001};

    #1;
    do_reset();
    step(12'hFF1, 32'h0, 1'b0, 1'b0, v, h, wr_o, q);
    chk("status_after_reset", q, 32'h001);

    // RAM pass-through and window gating of ram_wren
    step(12'h010, 32'h123, 1'b1, 1'b0, v, h, wr_o, q);
    chk("ram_wren_low_addr", {31'd0, wr_o}, 32'd1);
    step(12'h010, 32'h0, 1'b0, 1'b0, v, h, wr_o, q);
    chk("ram_readback", q, 32'h123);
    step(12'hFF0, 32'h77, 1'b1, 1'b0, v, h, wr_o, q);
    chk("ram_wren_window", {31'd0, wr_o}, 32'd0);

    // fill, overflow, clear, drain
    do_reset();
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].addr, tbl[i].wdata, tbl[i].wr, tbl[i].rdy, v, h, wr_o, q);
      chk($sformatf("tbl%0d_valid", i), {31'd0, v}, {31'd0, tbl[i].exp_valid});
      if (tbl[i].exp_valid) chk($sformatf("tbl%0d_head", i), h, tbl[i].exp_head);
      chk($sformatf("tbl%0d_rd", i), q, tbl[i].exp_rd);
    end

    // full FIFO with push and pop on the same edge
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(12'hFF0, 32'h100 + 32'(i), 1'b1, 1'b0, v, h, wr_o, q);
    step(12'hFF0, 32'h55, 1'b1, 1'b1, v, h, wr_o, q);
    step(12'hFF1, 32'h0, 1'b0, 1'b0, v, h, wr_o, q);
    chk("full_push_pop_status", q, 32'h042);

    // CYCLE load and wrap
    step(12'hFF2, 32'hFFFF_FFFE, 1'b1, 1'b0, v, h, wr_o, q);
    step(12'hFF3, 32'h0, 1'b0, 1'b0, v, h, wr_o, q);
    step(12'hFF3, 32'h0, 1'b0, 1'b0, v, h, wr_o, q);
    step(12'hFF2, 32'h0, 1'b0, 1'b0, v, h, wr_o, q);
    chk("cycle_wrap0", q, 32'h0);
    step(12'hFF2, 32'h0, 1'b0, 1'b0, v, h, wr_o, q);
`ifdef DMEM_RESP_CYCLE_COUNTER_EN
    chk("cycle_wrap1", q, 32'h1);
`else
    chk("cycle_wrap1", q, 32'h0);
`endif

    // reset while the FIFO holds three words
    do_reset();
    for (int i = 0; i < 3; i++) step(12'hFF0, 32'h200 + 32'(i), 1'b1, 1'b0, v, h, wr_o, q);
    chk("pre_reset_valid", {31'd0, out_valid}, 32'd1);
    do_reset();
    step(12'hFF1, 32'h0, 1'b0, 1'b0, v, h, wr_o, q);
    chk("status_after_midreset", q, 32'h001);

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       a = 12'hFF0;
        1:       a = 12'hFF1;
        2:       a = 12'hFF0 | 12'($urandom_range(2, 15));
        default: a = 12'($urandom_range(0, 31));
      endcase
      step(a, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), v, h, wr_o, q);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
